// File: rtl/ring_req_multi.sv
// ring_req_multi: N-channel ring token progress monitor; error/objective from registered state, 1-cycle visibility, no backpressure.
// Optional RING_REQ_STICKY_EN: err_vec bits latch high until reset_n.
module ring_req_multi #(
  parameter int N        = 4,
  parameter int K        = 8,
  parameter int LOSS_MAX = 2,
  parameter int OBJ_ALL  = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    restart,
  input  logic [N-1:0]            step,
  input  logic [N-1:0]            loss,
  input  logic [N-1:0]            ctrl_stable,
  output logic [N*$clog2(K)-1:0]  prg_o,
  output logic [N-1:0]            err_vec,
  output logic                    error,
  output logic                    objective
);

  localparam int PW = $clog2(K);
  localparam int LW = $clog2(LOSS_MAX + 1);
  localparam logic [PW-1:0] PRG_MAX   = PW'(K - 1);
  localparam logic [PW-1:0] PRG_PEN   = PW'(K - 2);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_MAX - 1);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic            run;
  logic [PW-1:0]   prg_q  [N];
  logic [PW-1:0]   prg_d  [N];
  logic [LW-1:0]   loss_q [N];
  logic [LW-1:0]   loss_d [N];
  logic [N-1:0]    stable_q, stable_d;
  logic [N-1:0]    fin;
  logic [N-1:0]    err_now;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Boot lasts exactly one edge; inputs are ignored while in it.
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  run     = 1'b1;
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N; i++) begin
      prg_d[i]  = prg_q[i];
      loss_d[i] = loss_q[i];
      if (run) begin
        if (restart) begin
          prg_d[i]    = '0;
          loss_d[i]   = '0;
          stable_d[i] = 1'b0;
        end else if (loss[i] && (loss_q[i] == LOSS_LAST)) begin
          prg_d[i]  = '0;
          loss_d[i] = '0;
        end else if (loss[i]) begin
          loss_d[i] = loss_q[i] + LW'(1);
        end else if (step[i]) begin
          loss_d[i] = '0;
          if (prg_q[i] != PRG_MAX) begin
            prg_d[i] = prg_q[i] + PW'(1);
            // Stability is only sampled on the final advance and never dropped here.
            if (prg_q[i] == PRG_PEN) begin
              stable_d[i] = stable_q[i] | ctrl_stable[i];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int i = 0; i < N; i++) begin
        prg_q[i]  <= '0;
        loss_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < N; i++) begin
        prg_q[i]  <= prg_d[i];
        loss_q[i] <= loss_d[i];
      end
    end
  end

  always_comb begin
    prg_o   = '0;
    fin     = '0;
    err_now = '0;
    for (int i = 0; i < N; i++) begin
      prg_o[i*PW +: PW] = prg_q[i];
      fin[i]            = (prg_q[i] == PRG_MAX);
      err_now[i]        = fin[i] & ~stable_q[i];
    end
  end

`ifdef RING_REQ_STICKY_EN
  logic [N-1:0] err_lat_q;

  // Latch survives restart; only reset_n clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_lat_q <= '0;
    end else begin
      err_lat_q <= err_lat_q | err_now;
    end
  end

  assign err_vec = err_lat_q | err_now;
`else
  assign err_vec = err_now;
`endif

  assign error     = |err_vec;
  assign objective = (OBJ_ALL != 0) ? (&fin) : (|fin);

endmodule
